// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: client read channels and unified memory port of mem_arbiter.
//   req0..2 / addr0..2 : client read requests (level) and word addresses
//   ack0..2 / rdata0..2: one-cycle completion pulses and returned read data
//   mem_req / mem_addr : unified memory request (level) and 17-bit address
//   mem_rdata / mem_ack: memory read data and completion
//   err / err_client   : sticky timeout flag and index of the last timed-out client
//   modport slave  : arbiter side
//   modport master : client/memory environment side
interface mem_arbiter_if;
  localparam int unsigned A0_W  = 12;
  localparam int unsigned A1_W  = 15;
  localparam int unsigned A2_W  = 12;
  localparam int unsigned MEM_W = 17;
  localparam int unsigned DAT_W = 32;

  logic               req0;
  logic               req1;
  logic               req2;
  logic [A0_W-1:0]    addr0;
  logic [A1_W-1:0]    addr1;
  logic [A2_W-1:0]    addr2;
  logic               ack0;
  logic               ack1;
  logic               ack2;
  logic [DAT_W-1:0]   rdata0;
  logic [DAT_W-1:0]   rdata1;
  logic [DAT_W-1:0]   rdata2;
  logic               mem_req;
  logic [MEM_W-1:0]   mem_addr;
  logic [DAT_W-1:0]   mem_rdata;
  logic               mem_ack;
  logic               err;
  logic [1:0]         err_client;

  modport slave (
    input  req0, req1, req2, addr0, addr1, addr2, mem_rdata, mem_ack,
    output ack0, ack1, ack2, rdata0, rdata1, rdata2, mem_req, mem_addr,
           err, err_client
  );

  modport master (
    output req0, req1, req2, addr0, addr1, addr2, mem_rdata, mem_ack,
    input  ack0, ack1, ack2, rdata0, rdata1, rdata2, mem_req, mem_addr,
           err, err_client
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one read-only memory port between
// the activation, layer-1 weight and layer-2 weight clients. Each client is
// mapped into its own address region, requests are serialised, read data is
// routed back, and a watchdog aborts transactions the memory never acks.
//   clk   : system clock, rising edge
//   rst_b : asynchronous reset, active high
//   bus   : client channels + memory port (mem_arbiter_if.slave)
// Parameters:
//   TIMEOUT  : ISSUE cycles waited for mem_ack before abort (1..65535)
//   ERR_DATA : data returned to a client on an aborted transaction
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic         clk,
  input  logic         rst_b,
  mem_arbiter_if.slave bus
);

  localparam int unsigned WD_W  = 16;
  localparam int unsigned MEM_W = 17;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned NCLI  = 3;
  // Watchdog value in the TIMEOUT-th ISSUE cycle (cleared to 0 on entry)
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t             r_state;
  logic [1:0]         r_ptr;
  logic [1:0]         r_gnt;
  logic [WD_W-1:0]    r_wd;
  logic               r_mem_req;
  logic [MEM_W-1:0]   r_mem_addr;
  logic [NCLI-1:0]    r_ack;
  logic [DAT_W-1:0]   r_rdata0;
  logic [DAT_W-1:0]   r_rdata1;
  logic [DAT_W-1:0]   r_rdata2;
  logic               r_err;
  logic [1:0]         r_err_client;

  logic [NCLI-1:0]    w_req;
  logic [1:0]         w_c0;
  logic [1:0]         w_c1;
  logic [1:0]         w_c2;
  logic               w_gnt_vld;
  logic [1:0]         w_gnt_idx;
  logic [MEM_W-1:0]   w_gnt_addr;
  logic               w_timeout;
  logic               w_done;
  logic [DAT_W-1:0]   w_resp_data;

  // Next client index, 2 wraps to 0
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Round-robin pick: first requester starting at the priority pointer
  always_comb begin
    w_req     = {bus.req2, bus.req1, bus.req0};
    w_c0      = r_ptr;
    w_c1      = wrap_inc(r_ptr);
    w_c2      = wrap_inc(w_c1);
    w_gnt_vld = |w_req;
    if (w_req[w_c0]) begin
      w_gnt_idx = w_c0;
    end else if (w_req[w_c1]) begin
      w_gnt_idx = w_c1;
    end else begin
      w_gnt_idx = w_c2;
    end
  end

  // Per-client address region in the unified memory
  always_comb begin
    case (w_gnt_idx)
      2'd0:    w_gnt_addr = {5'b00000, bus.addr0};
      2'd1:    w_gnt_addr = {2'b01,    bus.addr1};
      default: w_gnt_addr = {5'b10000, bus.addr2};
    endcase
  end

  // ISSUE completion: mem_ack wins over a coincident timeout
  always_comb begin
    w_timeout   = (r_wd == WD_LAST);
    w_done      = bus.mem_ack | w_timeout;
    w_resp_data = bus.mem_ack ? bus.mem_rdata : ERR_DATA;
  end

  // Arbiter FSM with registered outputs
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_state      <= S_IDLE;
      r_ptr        <= 2'd0;
      r_gnt        <= 2'd0;
      r_wd         <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_ack        <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_rdata2     <= '0;
      r_err        <= 1'b0;
      r_err_client <= 2'd0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_gnt      <= w_gnt_idx;
            r_ptr      <= wrap_inc(w_gnt_idx);
            r_mem_addr <= w_gnt_addr;
            r_mem_req  <= 1'b1;
            r_wd       <= '0;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_done) begin
            case (r_gnt)
              2'd0:    r_rdata0 <= w_resp_data;
              2'd1:    r_rdata1 <= w_resp_data;
              default: r_rdata2 <= w_resp_data;
            endcase
            if (!bus.mem_ack) begin
              r_err        <= 1'b1;
              r_err_client <= r_gnt;
            end
            r_ack[r_gnt] <= 1'b1;
            r_mem_req    <= 1'b0;
            r_state      <= S_RESP;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack0       = r_ack[0];
  assign bus.ack1       = r_ack[1];
  assign bus.ack2       = r_ack[2];
  assign bus.rdata0     = r_rdata0;
  assign bus.rdata1     = r_rdata1;
  assign bus.rdata2     = r_rdata2;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.err        = r_err;
  assign bus.err_client = r_err_client;

endmodule
